// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC stream engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } crc_state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Bits needed to hold values 0..v-1.
    function automatic int crc_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Framed input stream and result stream of the CRC engine, plus status outputs.
interface crc_stream_engine_if #(
    parameter int CRC_W  = 5,
    parameter int DATA_W = 24
);
    import crc_pkg::*;

    localparam int NBITS_W = crc_clog2(DATA_W + 1);

    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               s_sof;
    logic               s_eof;
    logic [NBITS_W-1:0] s_nbits;
    logic               s_mode;
    logic [CRC_W-1:0]   s_expect;
    logic               m_valid;
    logic               m_ready;
    logic [CRC_W-1:0]   m_crc;
    logic               m_match;
    logic               err_seq;
    logic [15:0]        err_cnt;

    modport master (
        output s_valid, s_data, s_sof, s_eof, s_nbits, s_mode, s_expect, m_ready,
        input  s_ready, m_valid, m_crc, m_match, err_seq, err_cnt
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, s_nbits, s_mode, s_expect, m_ready,
        output s_ready, m_valid, m_crc, m_match, err_seq, err_cnt
    );

endinterface

// File: rtl/crc_step_comb.sv
// Combinational LSB-first CRC update over up to DATA_W bits; nbits_i=0 means all DATA_W bits.
module crc_step_comb
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 5,
    parameter logic [CRC_W-1:0] POLY   = 5'h15,
    parameter int               DATA_W = 24,
    localparam int              NBITS_W = crc_clog2(DATA_W + 1)
) (
    input  logic [CRC_W-1:0]   lfsr_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [NBITS_W-1:0] nbits_i,
    output logic [CRC_W-1:0]   lfsr_o
);

    int         steps;
    logic       fb;
    logic [CRC_W-1:0] l;

    always_comb begin
        steps = (nbits_i == '0) ? DATA_W : int'(nbits_i);
        l     = lfsr_i;
        fb    = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < steps) begin
                fb = l[0] ^ data_i[i];
                l  = (l >> 1) ^ (fb ? POLY : '0);
            end
        end
        lfsr_o = l;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed CRC generator/checker with held result under backpressure.
// Optional saturating mismatch counter built when CRC_ERRCNT_EN is defined.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 5,
    parameter logic [CRC_W-1:0] POLY   = 5'h15,
    parameter int               DATA_W = 24,
    parameter logic [CRC_W-1:0] INIT   = '1,
    parameter logic [CRC_W-1:0] XOROUT = '0
) (
    input  logic          clk,
    input  logic          rst,
    crc_stream_engine_if.slave bus
);

    localparam int NBITS_W = crc_clog2(DATA_W + 1);

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             mode_q, mode_d;
    logic             match_q, match_d;
    logic             seq_q, seq_d;

    logic               fire;
    logic               take;
    logic               frame_mode;
    logic [CRC_W-1:0]   step_base;
    logic [CRC_W-1:0]   step_out;
    logic [CRC_W-1:0]   final_crc;
    logic [NBITS_W-1:0] step_nbits;

    assign fire       = bus.s_valid && (state_q != RESULT);
    // In IDLE only a sof beat opens a frame; anything else is dropped.
    assign take       = fire && ((state_q == ACCUM) || bus.s_sof);
    assign frame_mode = bus.s_sof ? bus.s_mode : mode_q;
    assign step_base  = bus.s_sof ? INIT : lfsr_q;
    assign step_nbits = bus.s_eof ? bus.s_nbits : '0;
    assign final_crc  = step_out ^ XOROUT;

    crc_step_comb #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .lfsr_i  (step_base),
        .data_i  (bus.s_data),
        .nbits_i (step_nbits),
        .lfsr_o  (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire && bus.s_sof) state_d = bus.s_eof ? RESULT : ACCUM;
            ACCUM:   if (fire && bus.s_eof) state_d = RESULT;
            RESULT:  if (bus.m_ready)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready = (state_q != RESULT);
        bus.m_valid = (state_q == RESULT);
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        crc_d   = crc_q;
        match_d = match_q;
        seq_d   = fire && (((state_q == IDLE) && !bus.s_sof) ||
                           ((state_q == ACCUM) && bus.s_sof));
        if (take) begin
            lfsr_d = step_out;
            mode_d = frame_mode;
            if (bus.s_eof) begin
                crc_d   = final_crc;
                match_d = (frame_mode == MODE_CHK) && (final_crc == bus.s_expect);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= INIT;
            mode_q  <= MODE_GEN;
            crc_q   <= '0;
            match_q <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            match_q <= match_d;
            seq_q   <= seq_d;
        end
    end

    assign bus.m_crc   = crc_q;
    assign bus.m_match = match_q;
    assign bus.err_seq = seq_q;

`ifdef CRC_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == RESULT) && bus.m_ready && (mode_q == MODE_CHK) &&
            !match_q && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized bench for crc_stream_engine against a bit-list CRC model.
module tb_crc_stream_engine;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   err_exp;

    crc_stream_engine_if #(.CRC_W(5), .DATA_W(24)) bus ();
    crc_stream_engine_if #(.CRC_W(5), .DATA_W(24)) bz ();

    crc_stream_engine #(
        .CRC_W(5), .POLY(5'h15), .DATA_W(24), .INIT(5'h1F), .XOROUT(5'h00)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    crc_stream_engine #(
        .CRC_W(5), .POLY(5'h15), .DATA_W(24), .INIT(5'h00), .XOROUT(5'h00)
    ) dut0 (.clk(clk), .rst(rst), .bus(bz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Flatten the frame into the bit sequence the spec consumes, then shift.
    function automatic logic [4:0] model_crc(input logic [23:0] w[$], input int nb,
                                             input logic [4:0] init);
        logic [4:0] r;
        bit         b[$];
        int         n;
        r = init;
        for (int k = 0; k < w.size(); k++) begin
            n = (k == w.size() - 1) ? ((nb == 0) ? 24 : nb) : 24;
            for (int i = 0; i < n; i++) b.push_back(w[k][i]);
        end
        foreach (b[i]) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 5'h15) : (r >> 1);
        return r ^ 5'h00;
    endfunction

    function automatic int err_step(input int e);
`ifdef CRC_ERRCNT_EN
        return (e < 65535) ? e + 1 : e;
`else
        return e;
`endif
    endfunction

    task automatic drive_beat(input logic [23:0] d, input logic sof, input logic eof,
                              input int nb, input logic mode, input logic [4:0] expv);
        int n;
        @(negedge clk);
        bus.s_valid  = 1'b1;
        bus.s_data   = d;
        bus.s_sof    = sof;
        bus.s_eof    = eof;
        bus.s_nbits  = 5'(nb);
        bus.s_mode   = mode;
        bus.s_expect = expv;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] w[$], input int nb, input logic mode,
                              input logic [4:0] expv);
        for (int k = 0; k < w.size(); k++)
            drive_beat(w[k], k == 0, k == w.size() - 1, nb, mode, expv);
    endtask

    task automatic get_result(input string tag, input logic [4:0] ecrc, input logic ematch,
                              input int delay);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd0);
        chk({tag, "_crc"}, 32'(bus.m_crc), 32'(ecrc));
        chk({tag, "_match"}, 32'(bus.m_match), 32'(ematch));
        repeat (delay) @(negedge clk);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
    endtask

    logic [23:0] w[$];
    logic [23:0] w2[$];
    logic [4:0]  c1;
    logic [4:0]  ev;
    logic        md;
    logic        em;
    int          nb;

    initial begin
        total = 0; bad = 0; err_exp = 0;
        rst = 1'b1;
        bus.s_valid = 0; bus.s_data = 0; bus.s_sof = 0; bus.s_eof = 0;
        bus.s_nbits = 0; bus.s_mode = 0; bus.s_expect = 0; bus.m_ready = 0;
        bz.s_valid = 0; bz.s_data = 0; bz.s_sof = 0; bz.s_eof = 0;
        bz.s_nbits = 0; bz.s_mode = 0; bz.s_expect = 0; bz.m_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_crc", 32'(bus.m_crc), 32'd0);
        chk("rst_m_match", 32'(bus.m_match), 32'd0);
        chk("rst_err_seq", 32'(bus.err_seq), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;

        // Full beat of zeros, then partial beat whose upper bits must be ignored.
        w = '{24'h000000};
        send_frame(w, 0, 1'b0, 5'h0);
        get_result("nb0", model_crc(w, 0, 5'h1F), 1'b0, 0);
        w = '{24'hABCD12};
        w2 = '{24'h000012};
        send_frame(w, 8, 1'b0, 5'h0);
        get_result("nb8", model_crc(w2, 8, 5'h1F), 1'b0, 1);

        // Mid-frame reset.
        drive_beat(24'h5A5A5A, 1'b1, 1'b0, 0, 1'b0, 5'h0);
        drive_beat(24'h123456, 1'b0, 1'b0, 0, 1'b0, 5'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("mrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mrst_m_crc", 32'(bus.m_crc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        w = '{24'h00C0DE};
        drive_beat(w[0], 1'b1, 1'b1, 0, 1'b0, 5'h0);
        chk("mrst_no_seq", 32'(bus.err_seq), 32'd0);
        get_result("mrst_new", model_crc(w, 0, 5'h1F), 1'b0, 0);

        // Check mode: generate, then check with correct and corrupted expectation.
        w = '{24'($urandom), 24'($urandom), 24'($urandom)};
        nb = $urandom_range(1, 24);
        c1 = model_crc(w, nb, 5'h1F);
        send_frame(w, nb, 1'b0, 5'h0);
        get_result("gen", c1, 1'b0, 0);
        send_frame(w, nb, 1'b1, c1);
        get_result("chk_ok", c1, 1'b1, 0);
        chk("chk_ok_errcnt", 32'(bus.err_cnt), 32'(err_exp));
        send_frame(w, nb, 1'b1, c1 ^ 5'h01);
        get_result("chk_bad", c1, 1'b0, 0);
        err_exp = err_step(err_exp);
        chk("chk_bad_errcnt", 32'(bus.err_cnt), 32'(err_exp));

        // Backpressure: result held, offered beat not consumed.
        w = '{24'($urandom), 24'($urandom)};
        c1 = model_crc(w, 0, 5'h1F);
        send_frame(w, 0, 1'b0, 5'h0);
        @(negedge clk);
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        bus.s_valid = 1'b1; bus.s_sof = 1'b1; bus.s_eof = 1'b1; bus.s_data = 24'hFFFFFF;
        for (int i = 0; i < 10; i++) begin
            chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
            chk("hold_crc", 32'(bus.m_crc), 32'(c1));
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_consume", 32'(bus.m_valid), 32'd0);
        end

        // Framing violations.
        drive_beat(24'h111111, 1'b0, 1'b0, 0, 1'b0, 5'h0);
        chk("idle_seq_hi", 32'(bus.err_seq), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_seq_lo", 32'(bus.err_seq), 32'd0);
        chk("idle_stay", 32'(bus.m_valid), 32'd0);
        w  = '{24'($urandom), 24'($urandom)};
        nb = $urandom_range(0, 24);
        drive_beat(24'hDEAD01, 1'b1, 1'b0, 0, 1'b0, 5'h0);
        drive_beat(w[0], 1'b1, 1'b0, 0, 1'b0, 5'h0);
        chk("accum_seq_hi", 32'(bus.err_seq), 32'd1);
        drive_beat(w[1], 1'b0, 1'b1, nb, 1'b0, 5'h0);
        chk("accum_seq_lo", 32'(bus.err_seq), 32'd0);
        get_result("restart", model_crc(w, nb, 5'h1F), 1'b0, 0);

        // INIT=0 instance.
        @(negedge clk);
        bz.s_valid = 1'b1; bz.s_sof = 1'b1; bz.s_eof = 1'b1; bz.s_data = 24'h0; bz.s_nbits = 5'd0;
        @(posedge clk);
        #1 bz.s_valid = 1'b0;
        @(negedge clk);
        chk("init0_valid", 32'(bz.m_valid), 32'd1);
        chk("init0_crc", 32'(bz.m_crc), 32'd0);
        bz.m_ready = 1'b1;
        @(posedge clk);
        #1 bz.m_ready = 1'b0;
        w = '{24'($urandom)};
        nb = $urandom_range(0, 24);
        @(negedge clk);
        bz.s_valid = 1'b1; bz.s_data = w[0]; bz.s_nbits = 5'(nb);
        @(posedge clk);
        #1 bz.s_valid = 1'b0;
        @(negedge clk);
        chk("init0_rand", 32'(bz.m_crc), 32'(model_crc(w, nb, 5'h00)));
        bz.m_ready = 1'b1;
        @(posedge clk);
        #1 bz.m_ready = 1'b0;

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            w.delete();
            for (int k = 0; k < $urandom_range(1, 4); k++) w.push_back(24'($urandom));
            nb = $urandom_range(0, 24);
            md = 1'($urandom);
            c1 = model_crc(w, nb, 5'h1F);
            ev = ($urandom_range(0, 1) == 1) ? c1 : 5'($urandom);
            em = md && (ev == c1);
            send_frame(w, nb, md, ev);
            get_result("rand", c1, em, $urandom_range(0, 3));
            if (md && !em) err_exp = err_step(err_exp);
        end
        chk("final_errcnt", 32'(bus.err_cnt), 32'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
